shared_bus_responder: RTL
=========================

Name: shared_bus_responder

Overview:
- Shared-bus responder and memory-side endpoint for the L2 cache's bus transactions: Read, Write (writeback), RFO and Invalidate.
- Each accepted request is broadcast to the other caches as a snoop, and the responder collects their snoop result.
- On HITM it absorbs the dirty line into backing memory first, then returns fill data plus the fill state (shared/exclusive) to the requesting L2.
- Sits between the L2 cache's shared-bus side and a behavioural backing memory.

Parameters:
addressSize, 32, address width
byteSelectBits, 6, line-offset bits dropped from the address
lineSize, 512, line and data width in bits
memDepth, 64, backing-memory lines; index = req_addr[byteSelectBits+$clog2(memDepth)-1:byteSelectBits]
memLatency, 4, memory access cycles (>=1)
snoopTimeout, 8, cycles to wait for snoop_valid before assuming NOHIT (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  L2 request valid
req_ready  out  1  responder idle and accepting
req_op  in  2  0=READ 1=WRITE 2=RFO 3=INVALIDATE
req_addr  in  addressSize  line address
req_data  in  lineSize  writeback data (WRITE only)
bus_op  out  8  snoop broadcast: ASCII "R" (READ), "M" (RFO), "I" (INVALIDATE), 0 when idle
bus_addr  out  addressSize  snooped address, valid while bus_op != 0
snoop_valid  in  1  snoop result present
snoop_result  in  2  0=NOHIT 1=HIT 2=HITM (3 is treated as NOHIT)
snoop_data  in  lineSize  dirty line, sampled with HITM
resp_valid  out  1  response valid
resp_ready  in  1  L2 accepts response
resp_op  out  2  echo of req_op
resp_shared  out  1  1 = fill in S, 0 = fill in E/M
resp_data  out  lineSize  fill data (0 for WRITE and INVALIDATE)

Behaviour:
- Clocking and reset: one clock, reset is synchronous and active-low.
- State after rst_n sampled low: state=IDLE; all outputs 0, including req_ready; every memory line = 0; counters = 0.
- req_ready = 1 from the first cycle after reset release, whenever in IDLE.
- Reset mid-transaction aborts it with no memory write and no response.
- FSM states: IDLE, BROADCAST, SNOOP, WRITEBACK, MEM, RESP.
- IDLE:
  - Accept on req_valid && req_ready; latch op, addr and data; req_ready drops the next cycle.
  - WRITE -> MEM.
  - All other ops -> BROADCAST.
- BROADCAST: exactly one cycle; bus_op/bus_addr driven; then -> SNOOP.
- SNOOP:
  - bus_op held at 0; wait counter starts at 0.
  - Exit on snoop_valid, or when the counter reaches snoopTimeout-1, which is treated as NOHIT.
  - Latch shared = (HIT or HITM).
  - HITM with READ or RFO: capture snoop_data -> WRITEBACK.
  - INVALIDATE: -> RESP (any result).
  - Otherwise -> MEM.
- WRITEBACK: memLatency cycles, then memory[index] <= captured snoop_data, then -> MEM.
- MEM: memLatency cycles.
  - WRITE: memory[index] <= req_data at the final cycle.
  - READ/RFO: resp_data <= memory[index] read at the final cycle, so it includes the just-written-back data.
  - Then -> RESP.
- RESP:
  - resp_valid=1; resp_op/resp_data/resp_shared held stable until resp_ready is sampled high.
  - resp_shared = latched shared for READ; 0 for RFO, WRITE and INVALIDATE.
  - On handshake: resp_valid=0 and -> IDLE; req_ready=1 the following cycle.
- snoop_valid outside SNOOP is ignored.
- A new req_valid while busy is not accepted; one transaction is in flight at a time.
- Address wrap: index uses only the low index bits; addresses differing only above the index alias to the same memory line.
- Latency (READ, NOHIT on the first SNOOP cycle, resp_ready held high): resp_valid rises 3+memLatency cycles after the accept edge.
- Each HITM adds memLatency cycles; each snoop wait cycle adds 1.

Test Plan:
- Reset, then WRITE addr 0x40 data 0xA5..A5 -> resp_valid 1+memLatency=5 cycles after accept; resp_data=0; bus_op stays 0 throughout.
- READ 0x40, snoop NOHIT on the first SNOOP cycle -> bus_op="R" for one cycle; resp_valid 7 cycles after accept; resp_data=0xA5..A5; resp_shared=0.
- READ 0x40, snoop HITM with snoop_data=0x3C..3C -> resp_data=0x3C..3C; resp_shared=1; a following NOHIT READ of 0x40 also returns 0x3C..3C.
- RFO 0x80, snoop_valid never asserted -> timeout after 8 SNOOP cycles; bus_op="M"; resp_shared=0; resp_data=0 (unwritten line).
- INVALIDATE 0x40, snoop HIT -> bus_op="I"; resp_valid 3 cycles after accept; memory unchanged (a later READ returns 0x3C..3C).
- Hold resp_ready=0 for 5 cycles, then pulse rst_n low during a later MEM phase -> response stays stable while stalled; after reset all outputs are 0, no write occurred, and req_ready=1 the cycle after release.

Source files
------------

// File: rtl/shared_bus_responder.sv
// Shared-bus responder: broadcasts L2 requests as snoops, absorbs HITM lines into
// backing memory and returns fill data with the fill state to the requesting L2.
module shared_bus_responder #(
  parameter int unsigned addressSize    = 32,
  parameter int unsigned byteSelectBits = 6,
  parameter int unsigned lineSize       = 512,
  parameter int unsigned memDepth       = 64,
  parameter int unsigned memLatency     = 4,
  parameter int unsigned snoopTimeout   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [addressSize-1:0] req_addr,
  input  logic [lineSize-1:0]    req_data,
  output logic [7:0]             bus_op,
  output logic [addressSize-1:0] bus_addr,
  input  logic                   snoop_valid,
  input  logic [1:0]             snoop_result,
  input  logic [lineSize-1:0]    snoop_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [1:0]             resp_op,
  output logic                   resp_shared,
  output logic [lineSize-1:0]    resp_data
);

  localparam int unsigned IDX_W   = $clog2(memDepth);
  localparam int unsigned CNT_MAX = (memLatency > snoopTimeout) ? memLatency : snoopTimeout;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RFO   = 2'd2;
  localparam logic [1:0] OP_INV   = 2'd3;
  localparam logic [1:0] SR_HIT   = 2'd1;
  localparam logic [1:0] SR_HITM  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_BROADCAST, S_SNOOP, S_WRITEBACK, S_MEM, S_RESP
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [lineSize-1:0]  line_q, line_d;
  logic                 shared_q, shared_d;
  logic                 req_ready_d, resp_valid_d, resp_shared_d;
  logic [1:0]           resp_op_d;
  logic [lineSize-1:0]  resp_data_d;
  logic [7:0]           bus_op_d;
  logic [addressSize-1:0] bus_addr_d;
  logic                 mem_we;
  logic                 snoop_hit, snoop_hitm, mem_last, snoop_last;
  logic [lineSize-1:0]  mem [memDepth];

  assign snoop_hit  = snoop_valid && (snoop_result == SR_HIT || snoop_result == SR_HITM);
  assign snoop_hitm = snoop_valid && (snoop_result == SR_HITM);
  assign mem_last   = (cnt == CNT_W'(memLatency - 1));
  assign snoop_last = (cnt == CNT_W'(snoopTimeout - 1));

  // Next-state, datapath and next output values.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt + CNT_W'(1);
    op_d          = op_q;
    idx_d         = idx_q;
    line_d        = line_q;
    shared_d      = shared_q;
    bus_op_d      = 8'h00;
    bus_addr_d    = '0;
    resp_valid_d  = resp_valid;
    resp_op_d     = resp_op;
    resp_shared_d = resp_shared;
    resp_data_d   = resp_data;
    mem_we        = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid && req_ready) begin
          op_d        = req_op;
          idx_d       = req_addr[byteSelectBits +: IDX_W];
          line_d      = req_data;
          shared_d    = 1'b0;
          resp_data_d = '0;
          if (req_op == OP_WRITE) begin
            state_d = S_MEM;
          end else begin
            state_d    = S_BROADCAST;
            bus_op_d   = (req_op == OP_RFO) ? 8'h4D : (req_op == OP_INV) ? 8'h49 : 8'h52;
            bus_addr_d = req_addr;
          end
        end
      end
      S_BROADCAST: begin
        cnt_d   = '0;
        state_d = S_SNOOP;
      end
      S_SNOOP: begin
        // A timeout falls through with snoop_hit/hitm low, i.e. NOHIT.
        if (snoop_valid || snoop_last) begin
          cnt_d    = '0;
          shared_d = snoop_hit;
          if (op_q == OP_INV) begin
            state_d = S_RESP;
          end else if (snoop_hitm) begin
            line_d  = snoop_data;
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_MEM;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_last) begin
          mem_we  = 1'b1;
          cnt_d   = '0;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_last) begin
          cnt_d   = '0;
          state_d = S_RESP;
          if (op_q == OP_WRITE) mem_we = 1'b1;
          else                  resp_data_d = mem[idx_q];
        end
      end
      S_RESP: begin
        cnt_d = '0;
        if (!resp_valid) begin
          resp_valid_d  = 1'b1;
          resp_op_d     = op_q;
          resp_shared_d = (op_q == OP_READ) && shared_q;
        end else if (resp_ready) begin
          resp_valid_d  = 1'b0;
          resp_op_d     = 2'd0;
          resp_shared_d = 1'b0;
          resp_data_d   = '0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Registered outputs, transaction context and backing memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= 2'd0;
      idx_q       <= '0;
      line_q      <= '0;
      shared_q    <= 1'b0;
      req_ready   <= 1'b0;
      bus_op      <= 8'h00;
      bus_addr    <= '0;
      resp_valid  <= 1'b0;
      resp_op     <= 2'd0;
      resp_shared <= 1'b0;
      resp_data   <= '0;
      for (int i = 0; i < int'(memDepth); i++) mem[i] <= '0;
    end else begin
      op_q        <= op_d;
      idx_q       <= idx_d;
      line_q      <= line_d;
      shared_q    <= shared_d;
      req_ready   <= req_ready_d;
      bus_op      <= bus_op_d;
      bus_addr    <= bus_addr_d;
      resp_valid  <= resp_valid_d;
      resp_op     <= resp_op_d;
      resp_shared <= resp_shared_d;
      resp_data   <= resp_data_d;
      if (mem_we) mem[idx_q] <= line_q;
    end
  end

endmodule
